// File: rtl/rnd_trigger_gen.sv
// rnd_trigger_gen: random L0 trigger generator.
// Fires when the LFSR word is below a programmable threshold, blocks further
// evaluation for a programmable dead time, timestamps each trigger into a
// small FIFO drained with a valid/ack handshake, and keeps trigger and drop
// counters for monitoring.
// Optional build macro: RND_TRIG_PRESCALE_EN (adds the prescale port; only
// every (prescale+1)-th fire is output).
module rnd_trigger_gen #(
  parameter int WIDTH      = 32,
  parameter int TS_WIDTH   = 32,
  parameter int DEAD_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      rnd_in,
  input  logic                  rnd_ready,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      threshold,
  input  logic [DEAD_WIDTH-1:0] dead_time,
`ifdef RND_TRIG_PRESCALE_EN
  input  logic [7:0]            prescale,
`endif
  output logic                  trig_out,
  output logic [TS_WIDTH-1:0]   ts_data,
  output logic                  ts_valid,
  input  logic                  ts_ack,
  output logic [31:0]           trig_count,
  output logic [15:0]           drop_count,
  output logic                  busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [DEAD_WIDTH-1:0] DEAD_ONE = DEAD_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ARMED, DEAD} state_t;

  state_t                state;
  logic [DEAD_WIDTH-1:0] dead_cnt;
  logic [TS_WIDTH-1:0]   ts_cnt;

  logic [TS_WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_next;
  logic [CNT_W-1:0]      count;

  logic eval;
  logic fire;
  logic emit;
  logic pop;
  logic full;
  logic accept;
  logic drop;

  // Evaluation happens only while armed with a valid random word present.
  assign eval = (state == ARMED) && enable && rnd_ready;
  assign fire = eval && (rnd_in < threshold);

`ifdef RND_TRIG_PRESCALE_EN
  logic [7:0] fire_cnt;
  assign emit = fire && (fire_cnt == prescale);
`else
  assign emit = fire;
`endif

  assign full    = (count == FULL_CNT);
  assign pop     = ts_valid && ts_ack;
  assign accept  = emit && (!full || pop);
  assign drop    = emit && full && !pop;
  assign rd_next = rd_ptr + 1'b1;

  assign ts_valid = (count != '0);
  assign busy     = (state == DEAD);

  // Free-running timestamp counter, wraps at 2^TS_WIDTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 1'b1;
  end

  // Trigger FSM with dead-time counter, registered pulse and trigger counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dead_cnt   <= '0;
      trig_out   <= 1'b0;
      trig_count <= '0;
`ifdef RND_TRIG_PRESCALE_EN
      fire_cnt   <= '0;
`endif
    end else begin
      trig_out <= emit;
      if (emit) trig_count <= trig_count + 1'b1;
`ifdef RND_TRIG_PRESCALE_EN
      if (fire) fire_cnt <= emit ? 8'd0 : fire_cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (enable && rnd_ready) state <= ARMED;
        end
        ARMED: begin
          if (!(enable && rnd_ready)) begin
            state <= IDLE;
          end else if (fire && (dead_time != '0)) begin
            dead_cnt <= dead_time;
            state    <= DEAD;
          end
        end
        DEAD: begin
          if (!enable) begin
            state    <= IDLE;
            dead_cnt <= '0;
          end else if (dead_cnt == DEAD_ONE) begin
            state    <= ARMED;
            dead_cnt <= '0;
          end else begin
            dead_cnt <= dead_cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          dead_cnt <= '0;
        end
      endcase
    end
  end

  // Timestamp storage; only the pointers and occupancy define what is valid.
  // NOTE: the memory array has no reset -- clearing pointers and occupancy is
  // enough to empty the FIFO, and an unreset array maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr] <= ts_cnt;
  end

  // FIFO pointers, occupancy, registered head word and drop counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ts_data    <= '0;
      drop_count <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_next;

      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Head register follows the entry that will sit at rd_ptr next cycle.
      if (accept && ((count == '0) || (pop && (count == ONE_CNT)))) begin
        ts_data <= ts_cnt;
      end else if (pop && (count > ONE_CNT)) begin
        ts_data <= mem[rd_next];
      end

      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rnd_trigger_gen.sv
// Directed self-checking bench for rnd_trigger_gen (default build).
module tb_rnd_trigger_gen;

  logic        clock;
  logic        reset;
  logic [31:0] rnd_in;
  logic        rnd_ready;
  logic        enable;
  logic [31:0] threshold;
  logic [15:0] dead_time;
  logic        trig_out;
  logic [31:0] ts_data;
  logic        ts_valid;
  logic        ts_ack;
  logic [31:0] trig_count;
  logic [15:0] drop_count;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  rnd_trigger_gen #(
    .WIDTH(32), .TS_WIDTH(32), .DEAD_WIDTH(16), .DEPTH(8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rnd_in     (rnd_in),
    .rnd_ready  (rnd_ready),
    .enable     (enable),
    .threshold  (threshold),
    .dead_time  (dead_time),
`ifdef RND_TRIG_PRESCALE_EN
    .prescale   (8'd0),
`endif
    .trig_out   (trig_out),
    .ts_data    (ts_data),
    .ts_valid   (ts_valid),
    .ts_ack     (ts_ack),
    .trig_count (trig_count),
    .drop_count (drop_count),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Reset across one edge; returns at cycle 0 (timestamp counter = 0).
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    rnd_in    = 32'hFE0F_DCBA;
    rnd_ready = 1'b1;
    enable    = 1'b1;
    threshold = 32'hFE0F_DCBB;
    dead_time = 16'd0;
    ts_ack    = 1'b0;

    // Continuous firing, FIFO fills then drops, then drained in order.
    do_reset();
    check("rst_trig_out",   trig_out,   0);
    check("rst_ts_valid",   ts_valid,   0);
    check("rst_ts_data",    ts_data,    0);
    check("rst_trig_count", trig_count, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_busy",       busy,       0);
    step(1);
    check("arm_no_trig", trig_out, 0);
    step(1);
    check("first_trig",     trig_out,   1);
    check("first_count",    trig_count, 1);
    check("first_ts_valid", ts_valid,   1);
    check("first_ts_data",  ts_data,    1);
    for (int c = 3; c <= 21; c++) begin
      step(1);
      check("cont_trig",  trig_out,   1);
      check("cont_count", trig_count, c - 1);
      check("cont_drop",  drop_count, (c >= 10) ? c - 9 : 0);
      check("cont_head",  ts_data,    1);
    end
    check("full_drop_12", drop_count, 12);
    enable = 1'b0;
    ts_ack = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      check("drain_valid", ts_valid, 1);
      check("drain_data",  ts_data,  j);
      step(1);
    end
    check("drained_empty", ts_valid,   0);
    check("drained_trig",  trig_out,   0);
    check("drained_drop",  drop_count, 12);
    check("drained_count", trig_count, 20);

    // Threshold equal to rnd_in never fires.
    enable = 1'b1;
    ts_ack = 1'b0;
    threshold = 32'hFE0F_DCBA;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      step(1);
      check("thr_eq_trig", trig_out, 0);
    end
    check("thr_eq_count", trig_count, 0);
    check("thr_eq_valid", ts_valid,   0);

    // Threshold zero never fires.
    threshold = 32'h0;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      step(1);
      check("thr_zero_trig", trig_out, 0);
    end
    check("thr_zero_count", trig_count, 0);
    check("thr_zero_valid", ts_valid,   0);

    // Threshold all-ones: all-ones word does not fire, all-ones minus one does.
    threshold = 32'hFFFF_FFFF;
    rnd_in    = 32'hFFFF_FFFF;
    do_reset();
    step(4);
    check("thr_max_nofire", trig_count, 0);
    rnd_in = 32'hFFFF_FFFE;
    step(1);
    check("thr_max_fire_trig",  trig_out,   1);
    check("thr_max_fire_count", trig_count, 1);
    check("thr_max_fire_ts",    ts_data,    4);

    // Full FIFO with ack held: push and pop together, no drops, ordered heads.
    rnd_in    = 32'hFE0F_DCBA;
    threshold = 32'hFE0F_DCBB;
    do_reset();
    step(9);
    check("full_valid", ts_valid,   1);
    check("full_drop0", drop_count, 0);
    ts_ack = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      check("fullpp_data",  ts_data,    1 + j);
      check("fullpp_valid", ts_valid,   1);
      check("fullpp_drop",  drop_count, 0);
      step(1);
    end

    // Push and pop together at occupancy 1: head becomes the new entry.
    do_reset();
    step(2);
    for (int c = 2; c <= 6; c++) begin
      check("occ1_data",  ts_data,  c - 1);
      check("occ1_valid", ts_valid, 1);
      step(1);
    end

    // Dead time 3: pulses 4 cycles apart, busy 3 cycles after each fire.
    ts_ack    = 1'b0;
    dead_time = 16'd3;
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      step(1);
      check("dead_trig", trig_out, (c >= 2) && ((c - 2) % 4 == 0));
      check("dead_busy", busy,     (c >= 2) && ((c - 2) % 4 != 3));
    end
    check("dead_count", trig_count, 3);
    check("dead_head",  ts_data,    1);
    check("dead_valid", ts_valid,   1);

    // Reset mid dead period with three queued timestamps.
    reset = 1'b1;
    #1;
    check("midrst_trig",  trig_out,   0);
    check("midrst_valid", ts_valid,   0);
    check("midrst_busy",  busy,       0);
    check("midrst_count", trig_count, 0);
    check("midrst_drop",  drop_count, 0);
    check("midrst_data",  ts_data,    0);
    step(1);
    reset = 1'b0;
    step(2);
    check("postrst_trig",  trig_out,   1);
    check("postrst_data",  ts_data,    1);
    check("postrst_count", trig_count, 1);
    check("postrst_busy",  busy,       1);
    ts_ack = 1'b1;
    step(1);
    check("postrst_single", ts_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rnd_trigger_gen.md
Name: rnd_trigger_gen

Overview:
- Consumes the pseudo-random word stream and ready flag from the LFSR stage.
- Turns them into a random L0 trigger pulse train with a programmable rate threshold and a programmable minimum spacing (dead time).
- Timestamps each trigger into a small FIFO that the downstream packet/readout logic drains with a valid/ack handshake.
- Keeps trigger and drop counters for monitoring.

Parameters:
- WIDTH, 32, width of rnd_in and threshold.
- TS_WIDTH, 32, timestamp counter width.
- DEAD_WIDTH, 16, dead_time width.
- DEPTH, 8, timestamp FIFO depth; power of 2, >= 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rnd_in  in  WIDTH  random word from the LFSR stage.
- rnd_ready  in  1  rnd_in is valid, level.
- enable  in  1  trigger generation enable.
- threshold  in  WIDTH  fire when rnd_in < threshold (unsigned).
- dead_time  in  DEAD_WIDTH  cycles blocked after each fire.
- trig_out  out  1  one-cycle trigger pulse.
- ts_data  out  TS_WIDTH  FIFO head timestamp.
- ts_valid  out  1  FIFO not empty.
- ts_ack  in  1  pop FIFO head when ts_valid=1.
- trig_count  out  32  total fires, wraps.
- drop_count  out  16  timestamps lost to a full FIFO; saturates at 0xFFFF.
- busy  out  1  state==DEAD.

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE;
  - ts counter, dead counter, FIFO pointers and occupancy all 0;
  - trig_out=0, ts_valid=0, ts_data=0, trig_count=0, drop_count=0, busy=0.
- Timestamp counter: increments every clock after reset and wraps at 2^TS_WIDTH.
- FSM transitions:
  - IDLE -> ARMED when enable && rnd_ready.
  - ARMED:
    - If !enable or !rnd_ready: go to IDLE, no evaluation.
    - Otherwise evaluate "fire" = (rnd_in < threshold).
    - On fire with dead_time==0: stay in ARMED, so the next cycle is evaluated again.
    - On fire with dead_time>0: load dead counter = dead_time and go to DEAD.
  - DEAD: dead counter decrements each cycle; at counter==1 go to ARMED. This gives exactly dead_time non-evaluating cycles. !enable in DEAD -> IDLE, counter cleared.
- Fire-to-output timing:
  - A fire evaluated in cycle N drives trig_out=1 in cycle N+1 only (registered, 1 cycle).
  - The same fire pushes the timestamp value of cycle N, and increments trig_count, visible in N+1.
  - Next possible evaluation is cycle N+dead_time+1.
- Threshold corners:
  - threshold=0: never fires.
  - threshold=all-ones: fires for every rnd_in except all-ones.
- FIFO:
  - ts_valid = occupancy!=0; ts_data = head entry, registered.
  - Pop on ts_valid && ts_ack. ts_ack while empty is ignored.
  - Push while full with no pop in the same cycle: timestamp discarded, drop_count += 1 (saturating); trig_out and trig_count still update.
  - Push and pop in the same cycle while full: both occur, no drop, occupancy unchanged.
  - Push and pop in the same cycle while occupancy 1: head becomes the new entry.
  - Pointers wrap modulo DEPTH.
- Input changes: threshold and dead_time are sampled only at evaluation and load time; changes take effect at the next evaluation.
- Reset mid-operation: aborts any dead period and empties the FIFO immediately.

Optional Feature:
- Macro: RND_TRIG_PRESCALE_EN.
- Defined:
  - Adds port prescale in 8 and an internal 8-bit fire counter (reset 0).
  - Only every (prescale+1)-th fire produces trig_out, a FIFO push and a trig_count increment; at that fire the counter reloads to 0.
  - Suppressed fires still start the dead period.
  - prescale=0 behaves identically to the undefined build.
- Undefined: no prescale port; every fire is output.

Test Plan:
1. rnd_in=0xFE0FDCBA constant, rnd_ready=1, enable=1, threshold=0xFE0FDCBB, dead_time=0 -> after the IDLE->ARMED cycle, trig_out=1 every cycle; trig_count increments by 1 per cycle.
2. Same stimulus but threshold=0xFE0FDCBA, and separately threshold=0 -> trig_out never asserts; trig_count=0, ts_valid=0.
3. Firing setup, dead_time=3 -> trig_out pulses spaced exactly 4 cycles apart; busy=1 for 3 cycles after each fire.
4. Firing setup, dead_time=0, ts_ack=0 for 20 cycles with DEPTH=8 -> ts_valid=1, 8 consecutive timestamps held; drop_count=12 (if the first fire occurs at cycle 0, window = 20 fires); then ack 8 cycles -> timestamps pop in push order, ts_valid=0 afterwards.
5. FIFO full with fires continuing and ts_ack=1 held -> drop_count unchanged; occupancy stays 8; each popped ts_data differs by 1 from the previous.
6. Assert reset for 1 cycle during DEAD with 3 entries in the FIFO -> immediately trig_out=0, ts_valid=0, busy=0, counters 0; after release, first evaluation fires and the FIFO contains only the new timestamp.
